// File: rtl/crc_pkg.sv
// crc_pkg
//   Shared definitions for the crc_stream engine: the FSM state encoding,
//   the cycles-per-word calculation and the parameter legality check.
package crc_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Number of SHIFT cycles needed to consume one input word.
    function automatic int cycles_per_word(input int data_w, input int bits_per_cyc);
        return data_w / bits_per_cyc;
    endfunction

    // A word must split into a whole number of per-cycle bit groups, and the
    // CRC register must fit in 1..32 bits.
    function automatic bit params_legal(input int crc_w, input int data_w, input int bits_per_cyc);
        return (crc_w >= 1) && (crc_w <= 32) && (data_w >= 1) && (bits_per_cyc >= 1)
            && (bits_per_cyc <= data_w) && ((data_w % bits_per_cyc) == 0);
    endfunction

endpackage

// File: rtl/crc_stream_if.sv
// crc_stream_if
//   Word-stream bus between a packet source (master) and the crc_stream
//   engine (slave).
//   master drives : clr, in_data, in_valid, in_last
//   slave drives  : in_ready, busy, word_done, crc_valid, crc
interface crc_stream_if #(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 8
);

    logic              clr;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              busy;
    logic              word_done;
    logic              crc_valid;
    logic [CRC_W-1:0]  crc;

    modport master (
        output clr, in_data, in_valid, in_last,
        input  in_ready, busy, word_done, crc_valid, crc
    );

    modport slave (
        input  clr, in_data, in_valid, in_last,
        output in_ready, busy, word_done, crc_valid, crc
    );

endinterface

// File: rtl/crc_lfsr_step.sv
// crc_lfsr_step
//   Combinational CRC update for BITS_PER_CYC serial bits.
//   reg_in  : CRC register before the update
//   bits_in : input bits, bits_in[BITS_PER_CYC-1] is applied first
//   reg_out : CRC register after all bits are applied
module crc_lfsr_step #(
    parameter int          CRC_W        = 8,
    parameter logic [31:0] POLY         = 32'h07,
    parameter int          BITS_PER_CYC = 1
) (
    input  logic [CRC_W-1:0]        reg_in,
    input  logic [BITS_PER_CYC-1:0] bits_in,
    output logic [CRC_W-1:0]        reg_out
);

    localparam logic [CRC_W-1:0] POLY_W = POLY[CRC_W-1:0];

    logic [CRC_W-1:0] acc;
    logic             fb;

    // Unrolled chain of single-bit LFSR steps; the shift drops the old top
    // bit, whose contribution is carried by the feedback term.
    always_comb begin
        acc = reg_in;
        fb  = 1'b0;
        for (int i = BITS_PER_CYC - 1; i >= 0; i--) begin
            fb  = acc[CRC_W-1] ^ bits_in[i];
            acc = (acc << 1) ^ (fb ? POLY_W : '0);
        end
        reg_out = acc;
    end

endmodule

// File: rtl/crc_stream.sv
// crc_stream
//   Parametrised CRC engine for framed word streams. Accepts one DATA_W-bit
//   word per valid/ready handshake and folds BITS_PER_CYC bits per clock into
//   the CRC register, pulsing word_done per word and crc_valid per frame.
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : crc_stream_if slave modport (clr, in_data, in_valid, in_last in;
//         in_ready, busy, word_done, crc_valid, crc out)
module crc_stream
    import crc_pkg::*;
#(
    parameter int          CRC_W        = 8,
    parameter logic [31:0] POLY         = 32'h07,
    parameter logic [31:0] INIT         = 32'h0,
    parameter logic [31:0] XOR_OUT      = 32'h0,
    parameter int          DATA_W       = 8,
    parameter int          BITS_PER_CYC = 1,
    parameter bit          MSB_FIRST    = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    crc_stream_if.slave  bus
);

    generate
        if (!params_legal(CRC_W, DATA_W, BITS_PER_CYC)) begin : g_bad_params
            $error("crc_stream: BITS_PER_CYC must divide DATA_W and CRC_W must be 1..32");
        end
    endgenerate

    localparam int               N        = cycles_per_word(DATA_W, BITS_PER_CYC);
    localparam int               CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
    localparam logic [CRC_W-1:0] INIT_W   = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOR_W    = XOR_OUT[CRC_W-1:0];
    localparam logic [0:0]       ST_IDLE  = IDLE;
    localparam logic [0:0]       ST_SHIFT = SHIFT;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              first_q, first_d;
    logic [CRC_W-1:0]  crc_q, crc_d;
    logic              word_done_q, word_done_d;
    logic              crc_valid_q, crc_valid_d;

    logic                    final_cyc;
    logic                    ready;
    logic                    accept;
    logic [BITS_PER_CYC-1:0] step_bits;
    logic [CRC_W-1:0]        step_base;
    logic [CRC_W-1:0]        step_out;
    logic [DATA_W-1:0]       data_shifted;

    // The last SHIFT cycle of a word can also accept the next word, which
    // is what gives one word per N cycles when the source keeps up.
    assign final_cyc = (state_q == ST_SHIFT) && (count_q == LAST_CNT);
    assign ready     = !bus.clr && ((state_q == ST_IDLE) || final_cyc);
    assign accept    = bus.in_valid && ready;

    // The register keeps the previous frame's result until the first update
    // of the next frame, so that update starts from INIT instead.
    assign step_base = first_q ? INIT_W : crc_q;

    // Pick this cycle's bit group so the first bit on the wire lands in the
    // top position of step_bits, which the step module applies first.
    always_comb begin
        step_bits = '0;
        for (int i = 0; i < BITS_PER_CYC; i++) begin
            if (MSB_FIRST) begin
                step_bits[i] = data_q[DATA_W - BITS_PER_CYC + i];
            end else begin
                step_bits[i] = data_q[BITS_PER_CYC - 1 - i];
            end
        end
        data_shifted = MSB_FIRST ? (data_q << BITS_PER_CYC) : (data_q >> BITS_PER_CYC);
    end

    crc_lfsr_step #(
        .CRC_W        (CRC_W),
        .POLY         (POLY),
        .BITS_PER_CYC (BITS_PER_CYC)
    ) u_step (
        .reg_in  (step_base),
        .bits_in (step_bits),
        .reg_out (step_out)
    );

    // Next-state logic. clr overrides everything and discards the word in
    // flight without any completion pulse.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        data_d      = data_q;
        last_d      = last_q;
        first_d     = first_q;
        crc_d       = crc_q;
        word_done_d = 1'b0;
        crc_valid_d = 1'b0;

        if (bus.clr) begin
            state_d = ST_IDLE;
            count_d = '0;
            crc_d   = INIT_W;
            first_d = 1'b1;
        end else begin
            if (state_q == ST_SHIFT) begin
                crc_d   = step_out;
                data_d  = data_shifted;
                first_d = 1'b0;
                count_d = count_q + 1'b1;
                if (final_cyc) begin
                    word_done_d = 1'b1;
                    crc_valid_d = last_q;
                    first_d     = last_q;
                    state_d     = ST_IDLE;
                    count_d     = '0;
                end
            end
            if (accept) begin
                data_d  = bus.in_data;
                last_d  = bus.in_last;
                count_d = '0;
                state_d = ST_SHIFT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            first_q     <= 1'b1;
            crc_q       <= INIT_W;
            word_done_q <= 1'b0;
            crc_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            data_q      <= data_d;
            last_q      <= last_d;
            first_q     <= first_d;
            crc_q       <= crc_d;
            word_done_q <= word_done_d;
            crc_valid_q <= crc_valid_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.busy      = (state_q == ST_SHIFT);
    assign bus.word_done = word_done_q;
    assign bus.crc_valid = crc_valid_q;
    assign bus.crc       = crc_q ^ XOR_W;

endmodule

// File: doc/crc_stream.md
Name: crc_stream

Overview:
Parametrised CRC engine for framed word streams, generalising the single-bit CRC-8 byte engine. It accepts DATA_W-bit words over a valid/ready handshake and consumes BITS_PER_CYC bits per clock. It has configurable polynomial, init value, output XOR and bit order. It sits between a packet source and the framer, and reports a per-word completion pulse and a per-frame CRC result.

Parameters:
CRC_W, 8, CRC register width (1..32)
POLY, 8'h07, generator polynomial, implicit top bit omitted
INIT, 0, register value at frame start and after clr
XOR_OUT, 0, value XORed into the register to form crc
DATA_W, 8, input word width
BITS_PER_CYC, 1, bits consumed per cycle; must divide DATA_W (elaboration error otherwise)
MSB_FIRST, 1, 1 = in_data[DATA_W-1] processed first; 0 = bit 0 first

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
clr  in  1  synchronous abort/clear of the current frame
in_data  in  DATA_W  word to process
in_valid  in  1  in_data/in_last valid
in_last  in  1  word is the final word of a frame
in_ready  out  1  engine can accept a word this cycle
busy  out  1  word in flight
word_done  out  1  one-cycle pulse: word fully processed
crc_valid  out  1  one-cycle pulse: frame CRC available on crc
crc  out  CRC_W  current register XOR XOR_OUT

Behaviour:
- Reset (rst high, async):
  - state IDLE, register = INIT, counter = 0, first-of-frame flag = 1.
  - in_ready = 1, busy = 0, word_done = 0, crc_valid = 0, crc = INIT^XOR_OUT.
- N = DATA_W/BITS_PER_CYC cycles per word.
- States:
  - IDLE: in_ready = 1. Accept (in_valid & in_ready) captures in_data and in_last, sets count = 0, and goes to SHIFT.
  - SHIFT: busy = 1. Each cycle applies BITS_PER_CYC serial LFSR steps (fb = reg[CRC_W-1] ^ bit; reg = {reg[CRC_W-2:0],0} ^ (fb ? POLY : 0)) in the MSB_FIRST order, then count increments.
    - in_ready = 1 only when count == N-1, giving back-to-back throughput of one word per N cycles.
    - At count == N-1: next state is SHIFT if a word is accepted that cycle, otherwise IDLE.
- Frame start: if the first-of-frame flag is set at accept, the first update step starts from INIT, not the stale register.
- Completion:
  - word_done is registered and pulses in the cycle after the final SHIFT cycle. An accept in cycle 0 gives word_done high in cycle N.
  - If the captured in_last = 1, crc_valid pulses in the same cycle as word_done and the first-of-frame flag is set.
  - crc holds that frame's value until the next frame's first update.
- in_ready does not depend on in_valid. in_data is sampled only on accept and is don't-care otherwise.
- clr (priority over accept and shifting): next cycle is IDLE with register = INIT and first-of-frame = 1. The in-flight word is discarded and neither word_done nor crc_valid pulses for it. A word presented with clr is not accepted (in_ready forced 0 while clr = 1).
- rst mid-word: immediate return to the reset state; no pulses.
- in_last on a single-word frame is legal: both pulses fire together.
- An accept in the final SHIFT cycle of a last word starts the new frame from INIT. The old frame's crc_valid pulse still fires, and crc shows the old result during that pulse.

Decomposition:
- Package crc_pkg: state enum {IDLE, SHIFT}; localparam function for N; parameter-legality check function.
- Sub-module crc_lfsr_step: purely combinational, parameters CRC_W, POLY, BITS_PER_CYC; ports reg_in, bits_in, reg_out. It chains BITS_PER_CYC single-bit steps.
- crc_stream holds the FSM, counter, data shift register and flags.

Test Plan:
- CRC_W=8, POLY=07, INIT=0, DATA_W=8, BITS=1: stream ASCII "123456789" (0x31..0x39), last on 0x39 -> crc_valid once, crc = 0xF4; nine word_done pulses each 8 cycles after accept.
- Same config, single word 0x01 with in_last -> crc = 0x07 at cycle 8; then single word 0x00 -> crc = 0x00, proving INIT reload between frames.
- CRC_W=16, POLY=1021, INIT=FFFF, BITS_PER_CYC=4, in_valid held high over "123456789" -> crc = 0x29B1; accepts spaced exactly 2 cycles, no idle gaps.
- clr asserted in 4th SHIFT cycle of word 0x31 -> no word_done or crc_valid; crc returns to INIT^XOR_OUT; following "123456789" frame still gives 0xF4.
- rst pulse mid-word, asynchronous and between clock edges -> outputs drop to reset values immediately; in_ready = 1 after release.
- MSB_FIRST=0, CRC_W=8, POLY=07, word 0x80 -> crc = 0x07 (bit-order mirror of the 0x01 case).
